irq_capture_arb: RTL and testbench

- Request-capture and arbitration stage directly upstream of the 8-to-3 priority encoder path.
- Edge-detects 8 raw request lines and holds them as sticky pending bits. Applies a per-line mask.
- Picks the highest-priority pending line (bit 7 highest, same ordering as the encoder) and presents its 3-bit index to the consumer over a valid/ready handshake.
- Clears the served bit on acceptance, so each request edge is delivered exactly once.

---
 rtl/irq_capture_arb.sv | 127 ++++++++++++
 tb/tb_irq_capture_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture_arb.sv
// irq_capture_arb
//   Request-capture and arbitration stage feeding the 8-to-3 priority
//   encoder path. Raw request lines are edge-detected into sticky pending
//   bits, masked, and the highest-index eligible line is presented as an
//   index over a valid/ready handshake. The served bit is cleared on
//   acceptance, so each request edge is delivered exactly once.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   d        raw request lines (level)
//   en       capture enable; 0 blocks new edges from setting pending
//   mask     1 = line eligible for arbitration (pending kept regardless)
//   clr      synchronous clear of all pending state and any open grant
//   q_valid  q holds a valid index
//   q_ready  consumer accepts q this cycle
//   q        index of granted line; holds last value while q_valid=0
//   pending  current pending bit vector
//   lost     sticky: an edge arrived on an already-pending line
module irq_capture_arb #(
   parameter int unsigned N    = 8,
   parameter int unsigned IDXW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    d,
   input  logic            en,
   input  logic [N-1:0]    mask,
   input  logic            clr,
   output logic            q_valid,
   input  logic            q_ready,
   output logic [IDXW-1:0] q,
   output logic [N-1:0]    pending,
   output logic            lost
);

   typedef enum logic {IDLE, PRESENT} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      d_q;
   logic [N-1:0]      pending_q, pending_d;
   logic [IDXW-1:0]   q_q, q_d;
   logic              lost_q, lost_d;

   logic [N-1:0]      rise;
   logic [N-1:0]      eligible;
   logic [N-1:0]      hs_vec;
   logic [IDXW-1:0]   sel;
   logic              hs;

   assign rise     = d & ~d_q;
   assign eligible = pending_q & mask;
   assign hs       = (state_q == PRESENT) && q_ready;

   // One-hot of the line being served this cycle (empty without a handshake).
   always_comb begin
      hs_vec = '0;
      if (hs) hs_vec[q_q] = 1'b1;
   end

   // Highest set bit of eligible wins; later iterations overwrite earlier.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (eligible[i]) sel = IDXW'(i);
      end
   end

   // Pending and lost: capture takes precedence over the handshake clear,
   // so a new edge on the line being served is retained.
   always_comb begin
      pending_d = pending_q;
      lost_d    = lost_q;
      if (clr) begin
         pending_d = '0;
         lost_d    = 1'b0;
      end else begin
         pending_d = (pending_q & ~hs_vec) | (rise & {N{en}});
         if (|(rise & {N{en}} & pending_q & ~hs_vec)) lost_d = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         d_q       <= '0;
         pending_q <= '0;
         q_q       <= '0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         d_q       <= d;
         pending_q <= pending_d;
         q_q       <= q_d;
         lost_q    <= lost_d;
      end
   end

   // Next-state logic; q is only loaded when a grant opens, so it stays
   // stable through PRESENT regardless of mask/pending changes.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      unique case (state_q)
         IDLE: begin
            if ((eligible != '0) && !clr) begin
               q_d     = sel;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (clr || q_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      q_valid = (state_q == PRESENT);
      q       = q_q;
      pending = pending_q;
      lost    = lost_q;
   end

endmodule

// File: tb/tb_irq_capture_arb.sv
module tb_irq_capture_arb;

   logic       clk;
   logic       rst;
   logic [7:0] d;
   logic       en;
   logic [7:0] mask;
   logic       clr;
   logic       q_valid;
   logic       q_ready;
   logic [2:0] q;
   logic [7:0] pending;
   logic       lost;

   int unsigned n_cmp;
   int unsigned n_bad;

   irq_capture_arb #(.N(8), .IDXW(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .d       (d),
      .en      (en),
      .mask    (mask),
      .clr     (clr),
      .q_valid (q_valid),
      .q_ready (q_ready),
      .q       (q),
      .pending (pending),
      .lost    (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst     = 1'b1;
      d       = '0;
      en      = 1'b1;
      mask    = 8'hFF;
      clr     = 1'b0;
      q_ready = 1'b1;
      tick();
      tick();
      check("rst_pending", 32'(pending), 32'h00);
      check("rst_valid",   32'(q_valid), 32'h0);
      check("rst_q",       32'(q),       32'h0);
      check("rst_lost",    32'(lost),    32'h0);
      rst = 1'b0;

      // 1: single request, line 0
      d = 8'h01;
      tick();
      check("t1_pend_set", 32'(pending), 32'h01);
      check("t1_valid_k",  32'(q_valid), 32'h0);
      tick();
      check("t1_valid",    32'(q_valid), 32'h1);
      check("t1_q",        32'(q),       32'h0);
      tick();
      check("t1_pulse",    32'(q_valid), 32'h0);
      check("t1_pend_clr", 32'(pending), 32'h00);
      tick();
      check("t1_level",    32'(q_valid), 32'h0);
      d = 8'h00;
      tick();

      // 2: two simultaneous requests, served 5 then 2
      d = 8'h24;
      tick();
      check("t2_pend24",   32'(pending), 32'h24);
      d = 8'h00;
      tick();
      check("t2_v5",       32'(q_valid), 32'h1);
      check("t2_q5",       32'(q),       32'h5);
      tick();
      check("t2_idle",     32'(q_valid), 32'h0);
      check("t2_pend04",   32'(pending), 32'h04);
      check("t2_qhold",    32'(q),       32'h5);
      tick();
      check("t2_v2",       32'(q_valid), 32'h1);
      check("t2_q2",       32'(q),       32'h2);
      tick();
      check("t2_done",     32'(q_valid), 32'h0);
      check("t2_pend00",   32'(pending), 32'h00);

      // 3: masked line stays pending but ungranted
      mask = 8'h7F;
      d    = 8'h80;
      tick();
      d = 8'h00;
      check("t3_pend80",   32'(pending), 32'h80);
      tick();
      tick();
      check("t3_masked",   32'(q_valid), 32'h0);
      check("t3_pendkeep", 32'(pending), 32'h80);
      mask = 8'hFF;
      tick();
      check("t3_v7",       32'(q_valid), 32'h1);
      check("t3_q7",       32'(q),       32'h7);
      tick();
      check("t3_done",     32'(pending), 32'h00);

      // 4: grant held stable while a higher line arrives
      q_ready = 1'b0;
      d = 8'h08;
      tick();
      d = 8'h00;
      tick();
      check("t4_v3",       32'(q_valid), 32'h1);
      check("t4_q3",       32'(q),       32'h3);
      d = 8'h40;
      tick();
      d = 8'h00;
      check("t4_pend48",   32'(pending), 32'h48);
      check("t4_q3_stab",  32'(q),       32'h3);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_hold_v", 32'(q_valid), 32'h1);
         check("t4_hold_q", 32'(q),       32'h3);
      end
      q_ready = 1'b1;
      tick();
      check("t4_acc",      32'(q_valid), 32'h0);
      check("t4_pend40",   32'(pending), 32'h40);
      tick();
      check("t4_v6",       32'(q_valid), 32'h1);
      check("t4_q6",       32'(q),       32'h6);
      tick();
      check("t4_done",     32'(pending), 32'h00);

      // 5: lost on re-edge of a pending line, then clr
      q_ready = 1'b0;
      d = 8'h02;
      tick();
      d = 8'h00;
      tick();
      check("t5_q1",       32'(q),       32'h1);
      check("t5_nolost",   32'(lost),    32'h0);
      d = 8'h02;
      tick();
      check("t5_lost",     32'(lost),    32'h1);
      d   = 8'h00;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t5_clr_pend", 32'(pending), 32'h00);
      check("t5_clr_lost", 32'(lost),    32'h0);
      check("t5_clr_v",    32'(q_valid), 32'h0);
      tick();
      check("t5_stay",     32'(q_valid), 32'h0);

      // 6: level held through reset, then en=0 blocks capture
      d   = 8'h10;
      rst = 1'b1;
      tick();
      tick();
      check("t6_rst_pend", 32'(pending), 32'h00);
      rst = 1'b0;
      tick();
      check("t6_pend10",   32'(pending), 32'h10);
      en = 1'b0;
      d  = 8'h11;
      tick();
      check("t6_en0",      32'(pending), 32'h10);
      check("t6_v4",       32'(q_valid), 32'h1);
      check("t6_q4",       32'(q),       32'h4);
      check("t6_nolost",   32'(lost),    32'h0);
      d = 8'h00;
      tick();
      check("t6_en0b",     32'(pending), 32'h10);

      // New edge on the served line in the handshake cycle is retained
      en      = 1'b1;
      d       = 8'h10;
      q_ready = 1'b1;
      tick();
      check("sb_pend",     32'(pending), 32'h10);
      check("sb_lost",     32'(lost),    32'h0);
      check("sb_idle",     32'(q_valid), 32'h0);
      tick();
      check("sb_regrant",  32'(q_valid), 32'h1);
      check("sb_q4",       32'(q),       32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
